dmem_wait_bytelane: RTL and testbench

Parametrised data memory for the pipelined MIPS core's MEM stage, the successor of the single-cycle word memory. Adds byte/halfword/word access with little-endian lane selection, sign/zero-extended loads, misalignment detection and a configurable wait-state request/ready handshake. A stall output holds the pipeline while an access is in flight. Storage is cleared on reset.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane.sv | 61 ++++++
 rtl/dmem_wait_bytelane.sv | 129 ++++++++++++
 tb/tb_dmem_wait_bytelane.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the wait-state byte-lane data memory.
// Used by dmem_lane and dmem_wait_bytelane (optional test port: DMEM_TESTPORT_EN).
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
// Combinational lane logic: store merge into the old word, load extract/extend,
// and misalignment decode for a little-endian 32-bit word.
`default_nettype none

module dmem_lane
  import dmem_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wd_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] new_word_o,
  output logic [31:0] rd_o,
  output logic        misalign_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign byte_sh = {lane_i, 3'b000};
  assign half_sh = {lane_i[1], 4'b0000};
  assign ld_byte = old_word_i[byte_sh +: 8];
  assign ld_half = old_word_i[half_sh +: 16];

  always_comb begin
    misalign_o = 1'b0;
    case (size_i)
      SZ_BYTE: misalign_o = 1'b0;
      SZ_HALF: misalign_o = lane_i[0];
      default: misalign_o = (lane_i != 2'b00);
    endcase
  end

  always_comb begin
    new_word_o = old_word_i;
    if (!misalign_o) begin
      case (size_i)
        SZ_BYTE: new_word_o[byte_sh +: 8]  = wd_i[7:0];
        SZ_HALF: new_word_o[half_sh +: 16] = wd_i[15:0];
        default: new_word_o                = wd_i;
      endcase
    end
  end

  always_comb begin
    rd_o = '0;
    if (!misalign_o) begin
      case (size_i)
        SZ_BYTE: rd_o = uns_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        SZ_HALF: rd_o = uns_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        default: rd_o = old_word_i;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_wait_bytelane.sv
// MEM-stage data memory with byte/half/word lanes and a wait-state req/ready handshake.
// Optional macro DMEM_TESTPORT_EN exposes word 0 on testValue.
`default_nettype none

module dmem_wait_bytelane
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        ready,
  output logic        stall,
  output logic        misalign
`ifdef DMEM_TESTPORT_EN
  ,
  output logic [31:0] testValue
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WS_C = CNT_W'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, uns_q;
  logic [1:0]          size_q;
  logic [AW+1:0]       addr_q;
  logic [31:0]         wd_q;
  logic [31:0]         mem_q [DEPTH];
  logic                accept;

  logic [31:0] lane_new, lane_rd, cur_word;
  logic        lane_mis;
  logic        w_unused_addr;

  // Upper address bits alias onto the array by design.
  assign w_unused_addr = ^addr[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    stall   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req) begin
          accept  = 1'b1;
          cnt_d   = WS_C;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_RESP;
      end
      ST_RESP: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= WE;
        uns_q  <= uns;
        size_q <= size;
        addr_q <= addr[AW+1:0];
        wd_q   <= WD;
      end
    end
  end

  assign cur_word = mem_q[addr_q[AW+1:2]];

  dmem_lane u_lane (
    .old_word_i (cur_word),
    .wd_i       (wd_q),
    .size_i     (size_q),
    .uns_i      (uns_q),
    .lane_i     (addr_q[1:0]),
    .new_word_o (lane_new),
    .rd_o       (lane_rd),
    .misalign_o (lane_mis)
  );

  // Store commits on the edge that leaves RESP, so a reset during WAIT drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ST_RESP && we_q && !lane_mis) begin
      mem_q[addr_q[AW+1:2]] <= lane_new;
    end
  end

  assign RD       = (state_q == ST_RESP && !we_q) ? lane_rd : 32'h0;
  assign misalign = (state_q == ST_RESP) && lane_mis;

`ifdef DMEM_TESTPORT_EN
  assign testValue = mem_q[0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_wait_bytelane.sv
// Scoreboard bench for dmem_wait_bytelane against a byte-array reference model.
`default_nettype none

module tb_dmem_wait_bytelane;

  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        WE = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] WD = '0;
  logic [31:0] RD;
  logic        ready, stall, misalign;
`ifdef DMEM_TESTPORT_EN
  logic [31:0] testValue;
`endif

  dmem_wait_bytelane #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .WE       (WE),
    .size     (size),
    .uns      (uns),
    .addr     (addr),
    .WD       (WD),
    .RD       (RD),
    .ready    (ready),
    .stall    (stall),
    .misalign (misalign)
`ifdef DMEM_TESTPORT_EN
    ,
    .testValue(testValue)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_load;
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rmem [NBYTE];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NBYTE; i++) rmem[i] = 8'h00;
  endtask

  // Memory as a flat little-endian byte array; aliasing is just modulo the byte count.
  function automatic exp_t ref_access(input logic we, input logic [1:0] sz, input logic u,
                                      input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int          ba, nb;
    logic [31:0] v;
    ba = int'(a % NBYTE);
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    e.is_load = !we;
    e.mis     = (ba % nb) != 0;
    e.rd      = '0;
    if (!e.mis) begin
      if (we) begin
        for (int k = 0; k < nb; k++) rmem[ba + k] = d[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (32'(rmem[ba + k]) << (8 * k));
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        e.rd = v;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(ready), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("misalign", 32'(misalign), 32'(e.mis));
          if (e.is_load) chk("load_rd", RD, e.rd);
        end
      end else begin
        chk("rd_idle_zero", RD, 32'h0);
        chk("mis_idle_zero", 32'(misalign), 32'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    int lat;
    @(negedge clk);
    chk("stall_no_req", 32'(stall), 32'h0);
    sb.push_back(ref_access(we, sz, u, a, d));
    req = 1'b1; WE = we; size = sz; uns = u; addr = a; WD = d;
    #1;
    chk("stall_req_cycle", 32'(stall), 32'h1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      chk("stall_vs_ready", 32'(stall), 32'(!ready));
      if (!ready) begin
        WE = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
        addr = $urandom; WD = $urandom;
      end
    end while (!ready && lat < 40);
    chk("latency", 32'(lat), 32'(WS + 1));
    if (!ready) sb.delete();
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_clear();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_mis", 32'(misalign), 32'h0);
    rst = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0011);
    // Abort a store while it is waiting: nothing may complete or be written.
    @(negedge clk);
    req = 1'b1; WE = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h10; WD = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    ref_clear();
    repeat (2) begin
      @(negedge clk);
      chk("abort_rst_ready", 32'(ready), 32'h0);
      chk("abort_rst_stall", 32'(stall), 32'h0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready", 32'(ready), 32'h0);
    end
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    issue(1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_00AB);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000_8001);
    issue(1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h0A, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h04, 32'h5555_AAAA);
    issue(1'b1, 2'b10, 1'b0, 32'h06, 32'hDEAD_DEAD);
    issue(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h00, 32'hCAFE_0001);
`ifdef DMEM_TESTPORT_EN
    @(negedge clk);
    chk("testValue", testValue, 32'hCAFE_0001);
`endif
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 32'h0C, 32'h8765_4321);
    issue(1'b0, 2'b11, 1'b1, 32'h0C, 32'h0);

    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom),
            $urandom & ~32'h0000_03C0, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
